// File: rtl/serial_arith_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : serial_arith_pkg
//  Description : Shared definitions for the bit-serial arithmetic blocks
//                (state encoding and default operand width).
//  Revision    : 1.0 - initial release
// ============================================================================
package serial_arith_pkg;

    // Default operand width for the serial arithmetic family
    localparam int DEFAULT_WIDTH = 8;

    // Sequencer state encoding, shared with the serial adder
    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_SHIFT = 2'd1,
        ST_DONE  = 2'd2
    } state_e;

endpackage
`default_nettype wire

// File: rtl/full_subtractor_bit.sv
`default_nettype none
// ============================================================================
//  Module      : full_subtractor_bit
//  Description : One-bit full subtractor (x - y - bin) built from two
//                half-subtractor slices whose borrows are ORed together.
//  Revision    : 1.0 - initial release
// ============================================================================
module full_subtractor_bit (
    input  logic x,
    input  logic y,
    input  logic bin,
    output logic d,
    output logic bout
);

    logic w_d1;
    logic w_b1;
    logic w_b2;

    // First half subtractor: x - y
    assign w_d1 = x ^ y;
    assign w_b1 = ~x & y;

    // Second half subtractor: (x - y) - bin
    assign d    = w_d1 ^ bin;
    assign w_b2 = ~w_d1 & bin;

    // Either stage may generate the outgoing borrow
    assign bout = w_b1 | w_b2;

endmodule
`default_nettype wire

// File: rtl/serial_subtractor.sv
`default_nettype none
// ============================================================================
//  Module      : serial_subtractor
//  Description : Bit-serial WIDTH-bit subtractor, DIFF = A - B, LSB first,
//                one bit per clock through a single full-subtractor slice
//                with a registered borrow. start/busy/done handshake.
//  Revision    : 1.0 - initial release
// ============================================================================
module serial_subtractor
    import serial_arith_pkg::*;
#(
    parameter int WIDTH = DEFAULT_WIDTH
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] diff,
    output logic             borrow_out,
    output logic             ovf
);

    localparam int             CW         = $clog2(WIDTH) + 1;
    localparam logic [CW-1:0]  C_CNT_LAST = CW'(WIDTH - 1);

    state_e            state_q,  state_d;
    logic [WIDTH-1:0]  a_sr_q,   a_sr_d;
    logic [WIDTH-1:0]  b_sr_q,   b_sr_d;
    logic [WIDTH-1:0]  d_sr_q,   d_sr_d;
    logic              br_q,     br_d;
    logic [CW-1:0]     cnt_q,    cnt_d;
    logic              a_msb_q,  a_msb_d;
    logic              b_msb_q,  b_msb_d;
    logic [WIDTH-1:0]  diff_q,   diff_d;
    logic              borrow_q, borrow_d;
    logic              ovf_q,    ovf_d;

    logic              w_bit_d;
    logic              w_bit_bout;
    logic [WIDTH-1:0]  w_d_sr_shift;
    logic              w_accept;

    // Single bit slice operating on the current LSBs and the held borrow
    full_subtractor_bit u_fs (
        .x    (a_sr_q[0]),
        .y    (b_sr_q[0]),
        .bin  (br_q),
        .d    (w_bit_d),
        .bout (w_bit_bout)
    );

    // New difference bit enters at the MSB so the result ends up aligned
    assign w_d_sr_shift = {w_bit_d, d_sr_q[WIDTH-1:1]};

    // A start is only honoured when no subtraction is in flight
    assign w_accept = start & (state_q != ST_SHIFT);

    // Next-state, datapath update and handshake outputs
    always_comb begin
        state_d  = state_q;
        a_sr_d   = a_sr_q;
        b_sr_d   = b_sr_q;
        d_sr_d   = d_sr_q;
        br_d     = br_q;
        cnt_d    = cnt_q;
        a_msb_d  = a_msb_q;
        b_msb_d  = b_msb_q;
        diff_d   = diff_q;
        borrow_d = borrow_q;
        ovf_d    = ovf_q;
        busy     = 1'b0;
        done     = 1'b0;

        case (state_q)
            ST_IDLE: begin
                state_d = ST_IDLE;
            end
            ST_SHIFT: begin
                busy   = 1'b1;
                a_sr_d = {1'b0, a_sr_q[WIDTH-1:1]};
                b_sr_d = {1'b0, b_sr_q[WIDTH-1:1]};
                d_sr_d = w_d_sr_shift;
                br_d   = w_bit_bout;
                cnt_d  = cnt_q + CW'(1);
                if (cnt_q == C_CNT_LAST) begin
                    diff_d   = w_d_sr_shift;
                    borrow_d = w_bit_bout;
                    // Overflow only possible when operand signs differ
                    ovf_d    = (a_msb_q != b_msb_q) &
                               (w_d_sr_shift[WIDTH-1] != a_msb_q);
                    state_d  = ST_DONE;
                end
            end
            ST_DONE: begin
                done    = 1'b1;
                state_d = ST_IDLE;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase

        // Launch a new operation (from IDLE or straight out of DONE)
        if (w_accept) begin
            a_sr_d  = a;
            b_sr_d  = b;
            d_sr_d  = '0;
            br_d    = 1'b0;
            cnt_d   = '0;
            a_msb_d = a[WIDTH-1];
            b_msb_d = b[WIDTH-1];
            state_d = ST_SHIFT;
        end
    end

    // State and datapath registers with synchronous reset
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q  <= ST_IDLE;
            a_sr_q   <= '0;
            b_sr_q   <= '0;
            d_sr_q   <= '0;
            br_q     <= 1'b0;
            cnt_q    <= '0;
            a_msb_q  <= 1'b0;
            b_msb_q  <= 1'b0;
            diff_q   <= '0;
            borrow_q <= 1'b0;
            ovf_q    <= 1'b0;
        end else begin
            state_q  <= state_d;
            a_sr_q   <= a_sr_d;
            b_sr_q   <= b_sr_d;
            d_sr_q   <= d_sr_d;
            br_q     <= br_d;
            cnt_q    <= cnt_d;
            a_msb_q  <= a_msb_d;
            b_msb_q  <= b_msb_d;
            diff_q   <= diff_d;
            borrow_q <= borrow_d;
            ovf_q    <= ovf_d;
        end
    end

    assign diff       = diff_q;
    assign borrow_out = borrow_q;
    assign ovf        = ovf_q;

endmodule
`default_nettype wire

// File: doc/serial_subtractor.md
Name: serial_subtractor

Overview:
Bit-serial WIDTH-bit subtractor that computes DIFF = A - B, one bit per clock, LSB first. Each step uses a single full-subtractor bit slice with a registered borrow. It is the subtraction counterpart to the team's adder blocks, for area-constrained datapaths. A start/busy/done handshake lets a simple controller launch an operation and collect the result.

Parameters:
WIDTH, 8, operand and result width in bits (legal range 2..32).

Ports:
clk  input  1  rising-edge clock
rst  input  1  synchronous, active-high reset
start  input  1  request pulse; sampled only when the block is not busy
a  input  WIDTH  minuend; captured on the accepted start edge
b  input  WIDTH  subtrahend; captured on the accepted start edge
busy  output  1  high while a subtraction is in progress
done  output  1  single-cycle pulse when diff/borrow_out/ovf update
diff  output  WIDTH  registered result A - B, modulo 2^WIDTH
borrow_out  output  1  unsigned borrow: 1 iff A < B (unsigned)
ovf  output  1  signed overflow of two's-complement A - B

Behaviour:
- Reset (rst=1 at a clk edge): state=IDLE; busy=0; done=0; diff=0; borrow_out=0; ovf=0. The internal shift registers, borrow register and bit counter clear to 0.
- rst takes priority over every other input. Reset mid-operation abandons the operation, and no done pulse is produced for it.
- States: IDLE, SHIFT, DONE.
- IDLE: busy=0, done=0. When start=1, on that edge: load a_sr=a, b_sr=b, d_sr=0, br=0, cnt=0, capture a_msb=a[WIDTH-1] and b_msb=b[WIDTH-1], then go to SHIFT.
- SHIFT: busy=1. On each edge:
  - d = a_sr[0] ^ b_sr[0] ^ br
  - br_next = (~a_sr[0] & b_sr[0]) | (~(a_sr[0]^b_sr[0]) & br)
  - a_sr and b_sr shift right by one
  - d_sr shifts right with d entering at bit WIDTH-1
  - cnt increments
- SHIFT exits when cnt==WIDTH-1 on that edge, i.e. after exactly WIDTH shift edges. On the exit edge:
  - diff <= final d_sr value (including the last bit)
  - borrow_out <= br_next
  - ovf <= (a_msb != b_msb) & (result MSB != a_msb)
  - next state is DONE
- DONE: busy=0, done=1 for exactly one cycle. Next state is IDLE. If start=1 in the DONE cycle, it is accepted exactly as in IDLE and the next state is SHIFT (back-to-back operation).
- Latency: with start sampled at edge k, done is high in the cycle after edge k+WIDTH. Throughput is one result per WIDTH+1 cycles.
- start while busy=1 is ignored. No queuing and no error flag.
- a and b are don't-care except on the accepting edge. Changing them mid-operation has no effect.
- diff, borrow_out and ovf hold their last values until the next completion. They do not change during SHIFT.
- Widths: the counter is $clog2(WIDTH)+1 bits. All arithmetic is modulo 2^WIDTH. No X may propagate from unused shift-register bits.

Decomposition:
- Shared package serial_arith_pkg holds:
  - state encoding constants ST_IDLE=2'd0, ST_SHIFT=2'd1, ST_DONE=2'd2
  - a default-width constant, so it can be reused by the future serial adder.
- One combinational sub-module, full_subtractor_bit (inputs x, y, bin; outputs d, bout), built from two half-subtractor slices plus an OR.
- The FSM, shift registers, counter and result registers stay in serial_subtractor.

Test Plan:
- Reset, then a=8'h5A, b=8'h23, pulse start → busy=1 for 8 cycles, then done=1 for one cycle; diff=8'h37, borrow_out=0, ovf=0.
- a=8'h10, b=8'h20 → diff=8'hF0, borrow_out=1, ovf=0. Then a=8'h00, b=8'h01 → diff=8'hFF, borrow_out=1.
- Signed overflow: a=8'h80, b=8'h01 → diff=8'h7F, borrow_out=0, ovf=1. Then a=8'h7F, b=8'hFF → diff=8'h80, borrow_out=1, ovf=1.
- start re-pulsed at busy cycle 3 with a=8'hFF, b=8'h00 (original op a=8'hFF, b=8'hFF) → ignored; diff=8'h00, borrow_out=0, with exactly one done pulse.
- start held high through the DONE cycle with new operands a=8'h09, b=8'h04 → second op accepted immediately; second done arrives 9 cycles after the first with diff=8'h05.
- rst asserted at busy cycle 4 → next cycle busy=0, done=0, diff=0, borrow_out=0, ovf=0, and no done pulse follows for the abandoned op.
